// File: rtl/hazard3_cjtag_oscan1_adapter.sv
// Hazard3 cJTAG OScan1 adapter: oversamples 2-pin TCKC/TMSC and drives a 4-wire JTAG DTM.
// Define HAZARD3_CJTAG_ESC_RESET_EN to add the tap_trst_n pulse on reset escapes.
module hazard3_cjtag_oscan1_adapter #(
  parameter int unsigned N_SYNC = 2,
  parameter logic [11:0] OAC    = 12'h00c
) (
  input  logic clk,
  input  logic trst_n,
  input  logic tckc,
  input  logic tmsc_i,
  output logic tmsc_o,
  output logic tmsc_oe,
  output logic tck,
  output logic tms,
  output logic tdi,
  input  logic tdo,
  output logic online
`ifdef HAZARD3_CJTAG_ESC_RESET_EN
  ,
  output logic tap_trst_n
`endif
);

  typedef enum logic [2:0] {
    StOffline,
    StOac,
    StNtdi,
    StTms,
    StTdo
  } state_e;

  logic [N_SYNC-1:0] tckc_sync_q, tmsc_sync_q;
  logic              tckc_prev_q, tmsc_prev_q;
  logic              tckc_s, tmsc_s;
  logic              rise, fall, toggle;

  // One extra bit so that a saturated count of 8 is distinguishable from a select (6-7).
  logic [3:0]        esc_cnt_q, esc_cnt_d;
  logic              esc_desel, esc_sel, esc_rst, esc_any;

  state_e            state_q, state_d;
  logic [11:0]       oac_sr_q, oac_sr_d;
  logic [3:0]        oac_cnt_q, oac_cnt_d;
  logic [11:0]       oac_next;
  logic              tms_armed_q, tms_armed_d;
  logic [1:0]        tdo_dly_q, tdo_dly_d;
  logic              tck_q, tck_d;
  logic              tms_q, tms_d;
  logic              tdi_q, tdi_d;
  logic              tmsc_o_q, tmsc_o_d;
  logic              tmsc_oe_q, tmsc_oe_d;
  logic              online_q, online_d;

  always_ff @(posedge clk or negedge trst_n) begin
    if (!trst_n) begin
      tckc_sync_q <= '0;
      tmsc_sync_q <= '0;
      tckc_prev_q <= 1'b0;
      tmsc_prev_q <= 1'b0;
    end else begin
      tckc_sync_q <= N_SYNC'({tckc_sync_q, tckc});
      tmsc_sync_q <= N_SYNC'({tmsc_sync_q, tmsc_i});
      tckc_prev_q <= tckc_s;
      tmsc_prev_q <= tmsc_s;
    end
  end

  assign tckc_s = tckc_sync_q[N_SYNC-1];
  assign tmsc_s = tmsc_sync_q[N_SYNC-1];
  assign rise   = tckc_s & ~tckc_prev_q;
  assign fall   = ~tckc_s & tckc_prev_q;
  assign toggle = tmsc_s ^ tmsc_prev_q;

  always_comb begin
    esc_cnt_d = esc_cnt_q;
    if (rise || fall) begin
      esc_cnt_d = '0;
    end else if (tckc_s && toggle && !esc_cnt_q[3]) begin
      esc_cnt_d = esc_cnt_q + 4'd1;
    end
  end

  assign esc_desel = fall & (esc_cnt_q[3:1] == 3'b010);
  assign esc_sel   = fall & (esc_cnt_q[3:1] == 3'b011);
  assign esc_rst   = fall & esc_cnt_q[3];
  assign esc_any   = esc_desel | esc_sel | esc_rst;
  assign oac_next  = {tmsc_s, oac_sr_q[11:1]};

`ifdef HAZARD3_CJTAG_ESC_RESET_EN
  logic [1:0] rst_sr_q;

  always_ff @(posedge clk or negedge trst_n) begin
    if (!trst_n) begin
      rst_sr_q <= 2'b00;
    end else if (esc_rst) begin
      rst_sr_q <= 2'b11;
    end else begin
      rst_sr_q <= {rst_sr_q[0], 1'b0};
    end
  end

  assign tap_trst_n = ~rst_sr_q[1];
`endif

  always_comb begin
    state_d     = state_q;
    oac_sr_d    = oac_sr_q;
    oac_cnt_d   = oac_cnt_q;
    tms_armed_d = tms_armed_q;
    tdo_dly_d   = tdo_dly_q;
    tck_d       = tck_q;
    tms_d       = tms_q;
    tdi_d       = tdi_q;
    tmsc_o_d    = tmsc_o_q;
    tmsc_oe_d   = tmsc_oe_q;

    case (state_q)
      StOac: begin
        if (rise) begin
          oac_sr_d  = oac_next;
          oac_cnt_d = oac_cnt_q + 4'd1;
          if (oac_cnt_q == 4'd11) begin
            state_d = (oac_next == OAC) ? StNtdi : StOffline;
          end
        end
      end
      StNtdi: begin
        if (rise) begin
          tdi_d   = ~tmsc_s;
          state_d = StTms;
        end
      end
      StTms: begin
        if (rise) begin
          tms_d       = tmsc_s;
          tms_armed_d = 1'b1;
        end
        // tck rises one clk after tms is updated so the DTM sees settled tms/tdi.
        if (tms_armed_q) begin
          tck_d = 1'b1;
        end
        if (fall && tms_armed_q) begin
          tck_d       = 1'b0;
          tms_armed_d = 1'b0;
          tdo_dly_d   = 2'd0;
          state_d     = StTdo;
        end
      end
      StTdo: begin
        if (tdo_dly_q != 2'd2) begin
          tdo_dly_d = tdo_dly_q + 2'd1;
        end
        if (tdo_dly_q == 2'd1) begin
          tmsc_oe_d = 1'b1;
          tmsc_o_d  = tdo;
        end
        if (rise) begin
          state_d = StNtdi;
        end
      end
      StOffline: ;
      default: state_d = StOffline;
    endcase

    if (fall) begin
      tmsc_oe_d = 1'b0;
    end

    if (esc_desel || esc_rst) begin
      state_d = StOffline;
    end
    if (esc_sel) begin
      state_d   = StOac;
      oac_cnt_d = '0;
      oac_sr_d  = '0;
    end
    if (esc_any) begin
      tck_d       = 1'b0;
      tms_armed_d = 1'b0;
      tmsc_oe_d   = 1'b0;
    end
`ifdef HAZARD3_CJTAG_ESC_RESET_EN
    if (esc_rst) begin
      tms_d = 1'b1;
    end
`endif

    online_d = (state_d == StNtdi) || (state_d == StTms) || (state_d == StTdo);
  end

  always_ff @(posedge clk or negedge trst_n) begin
    if (!trst_n) begin
      state_q     <= StOffline;
      oac_sr_q    <= '0;
      oac_cnt_q   <= '0;
      esc_cnt_q   <= '0;
      tms_armed_q <= 1'b0;
      tdo_dly_q   <= '0;
      tck_q       <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b1;
      tmsc_o_q    <= 1'b0;
      tmsc_oe_q   <= 1'b0;
      online_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      oac_sr_q    <= oac_sr_d;
      oac_cnt_q   <= oac_cnt_d;
      esc_cnt_q   <= esc_cnt_d;
      tms_armed_q <= tms_armed_d;
      tdo_dly_q   <= tdo_dly_d;
      tck_q       <= tck_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      tmsc_o_q    <= tmsc_o_d;
      tmsc_oe_q   <= tmsc_oe_d;
      online_q    <= online_d;
    end
  end

  assign tck     = tck_q;
  assign tms     = tms_q;
  assign tdi     = tdi_q;
  assign tmsc_o  = tmsc_o_q;
  assign tmsc_oe = tmsc_oe_q;
  assign online  = online_q;

endmodule

// File: tb/tb_hazard3_cjtag_oscan1_adapter.sv
// Bench for the OScan1 adapter: host-side cJTAG driver, behavioural TAP model and scoreboard.
module tb_hazard3_cjtag_oscan1_adapter;

  localparam logic [11:0] OAC_V = 12'h00c;

  logic clk = 1'b0;
  logic trst_n = 1'b0;
  logic tckc = 1'b0;
  logic tmsc_i = 1'b0;
  logic tmsc_o, tmsc_oe, tck, tms, tdi, online;
  logic tdo_r = 1'b0;
`ifdef HAZARD3_CJTAG_ESC_RESET_EN
  logic tap_trst_n;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard3_cjtag_oscan1_adapter #(
    .N_SYNC(2),
    .OAC   (OAC_V)
  ) dut (
    .clk       (clk),
    .trst_n    (trst_n),
    .tckc      (tckc),
    .tmsc_i    (tmsc_i),
    .tmsc_o    (tmsc_o),
    .tmsc_oe   (tmsc_oe),
    .tck       (tck),
    .tms       (tms),
    .tdi       (tdi),
    .tdo       (tdo_r),
    .online    (online)
`ifdef HAZARD3_CJTAG_ESC_RESET_EN
    ,
    .tap_trst_n(tap_trst_n)
`endif
  );

  // ---------------- Behavioural JTAG TAP (the DTM side) ----------------
  localparam int TLR = 0, RTI = 1, SELDR = 2, CAPDR = 3, SHDR = 4, EX1DR = 5, PADR = 6;
  localparam int EX2DR = 7, UPDR = 8, SELIR = 9, CAPIR = 10, SHIR = 11, EX1IR = 12;
  localparam int PAIR = 13, EX2IR = 14, UPIR = 15;

  int          tap_state = TLR;
  logic [31:0] tap_dr = '0;
  logic [31:0] idcode_val;
  logic [1:0]  obs [0:1023];
  int          obs_n = 0;

  function automatic int tap_next(int s, logic m);
    case (s)
      TLR:     return m ? TLR : RTI;
      RTI:     return m ? SELDR : RTI;
      SELDR:   return m ? SELIR : CAPDR;
      CAPDR:   return m ? EX1DR : SHDR;
      SHDR:    return m ? EX1DR : SHDR;
      EX1DR:   return m ? UPDR : PADR;
      PADR:    return m ? EX2DR : PADR;
      EX2DR:   return m ? UPDR : SHDR;
      UPDR:    return m ? SELDR : RTI;
      SELIR:   return m ? TLR : CAPIR;
      CAPIR:   return m ? EX1IR : SHIR;
      SHIR:    return m ? EX1IR : SHIR;
      EX1IR:   return m ? UPIR : PAIR;
      PAIR:    return m ? EX2IR : PAIR;
      EX2IR:   return m ? UPIR : SHIR;
      default: return m ? SELDR : RTI;
    endcase
  endfunction

  always @(posedge tck) begin
    if (tap_state == CAPDR) tap_dr <= idcode_val;
    else if (tap_state == SHDR) tap_dr <= {tdi, tap_dr[31:1]};
    tap_state   <= tap_next(tap_state, tms);
    obs[obs_n]  <= {tdi, tms};
    obs_n       <= obs_n + 1;
  end

  always @(negedge tck) tdo_r <= (tap_state == SHDR) ? tap_dr[0] : 1'b0;

  // Cycle monitors, sampled on the inactive clock edge.
  int oe_cnt = 0;
  int online_cnt = 0;
  int trst_lo_cnt = 0;
  int trst_tms_bad = 0;
  always @(negedge clk) begin
    if (tmsc_oe) oe_cnt <= oe_cnt + 1;
    if (online) online_cnt <= online_cnt + 1;
`ifdef HAZARD3_CJTAG_ESC_RESET_EN
    if (!tap_trst_n) begin
      trst_lo_cnt <= trst_lo_cnt + 1;
      if (tms !== 1'b1) trst_tms_bad <= trst_tms_bad + 1;
    end
`endif
  end

  // ---------------- Host-side cJTAG driver ----------------
  task automatic clk_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tckc_bit(input logic b);
    tmsc_i = b;
    clk_wait(4);
    tckc = 1'b1;
    clk_wait(8);
    tckc = 1'b0;
    clk_wait(4);
  endtask

  task automatic escape(input int n);
    tckc = 1'b1;
    clk_wait(4);
    for (int i = 0; i < n; i++) begin
      tmsc_i = ~tmsc_i;
      clk_wait(4);
    end
    clk_wait(2);
    tckc = 1'b0;
    clk_wait(8);
  endtask

  task automatic send_packet(input logic tdi_v, input logic tms_v, output logic tdo_v,
                             output logic oe_v);
    tckc_bit(~tdi_v);
    tckc_bit(tms_v);
    clk_wait(4);
    tckc = 1'b1;
    clk_wait(4);
    tdo_v = tmsc_o;
    oe_v  = tmsc_oe;
    clk_wait(4);
    tckc = 1'b0;
    clk_wait(4);
  endtask

  task automatic send_oac(input logic [11:0] code);
    logic [11:0] c;
    c = code;
    for (int i = 0; i < 12; i++) tckc_bit(c[i]);
  endtask

  task automatic activate();
    escape(6 + int'($urandom_range(0, 1)));
    send_oac(OAC_V);
    clk_wait(2);
  endtask

  // ---------------- Tests ----------------
  task automatic test_reset();
    trst_n = 1'b0;
    clk_wait(3);
    for (int pass = 0; pass < 2; pass++) begin
      checks += 6;
      if (tck !== 1'b0) begin errors++; $display("FAIL reset_tck: got %b want 0", tck); end
      if (tms !== 1'b1) begin errors++; $display("FAIL reset_tms: got %b want 1", tms); end
      if (tdi !== 1'b1) begin errors++; $display("FAIL reset_tdi: got %b want 1", tdi); end
      if (tmsc_o !== 1'b0) begin errors++; $display("FAIL reset_tmsc_o: got %b want 0", tmsc_o); end
      if (tmsc_oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b want 0", tmsc_oe); end
      if (online !== 1'b0) begin errors++; $display("FAIL reset_online: got %b want 0", online); end
`ifdef HAZARD3_CJTAG_ESC_RESET_EN
      checks++;
      if (tap_trst_n !== 1'b1) begin
        errors++; $display("FAIL reset_tap_trst_n: got %b want 1", tap_trst_n);
      end
`endif
      trst_n = 1'b1;
      clk_wait(4);
    end
  endtask

  task automatic test_idle_offline();
    int t0, o0, n0;
    t0 = obs_n; o0 = oe_cnt; n0 = online_cnt;
    for (int i = 0; i < 10; i++) tckc_bit(1'($urandom));
    checks += 3;
    if (obs_n != t0) begin errors++; $display("FAIL idle_tck: got %0d pulses want 0", obs_n - t0); end
    if (oe_cnt != o0) begin errors++; $display("FAIL idle_oe: got %0d cycles want 0", oe_cnt - o0); end
    if (online_cnt != n0) begin
      errors++; $display("FAIL idle_online: got %0d cycles want 0", online_cnt - n0);
    end
  endtask

  task automatic test_activate();
    logic [11:0] c;
    c = OAC_V;
    escape(6 + int'($urandom_range(0, 1)));
    checks++;
    if (online !== 1'b0) begin errors++; $display("FAIL act_after_sel: got %b want 0", online); end
    for (int i = 0; i < 11; i++) tckc_bit(c[i]);
    checks++;
    if (online !== 1'b0) begin errors++; $display("FAIL act_11bits: got %b want 0", online); end
    tckc_bit(c[11]);
    checks++;
    if (online !== 1'b1) begin errors++; $display("FAIL act_12bits: got %b want 1", online); end
  endtask

  task automatic test_tlr_idle();
    logic tdo_v, oe_v;
    logic [1:0] exp [6];
    int t0, bad;
    t0 = obs_n;
    for (int i = 0; i < 6; i++) begin
      exp[i] = {1'($urandom), (i < 5) ? 1'b1 : 1'b0};
      send_packet(exp[i][1], exp[i][0], tdo_v, oe_v);
    end
    checks += 3;
    if (obs_n - t0 != 6) begin errors++; $display("FAIL tlr_pulses: got %0d want 6", obs_n - t0); end
    if (tap_state != RTI) begin
      errors++; $display("FAIL tlr_tap_state: got %0d want %0d", tap_state, RTI);
    end
    bad = 0;
    for (int i = 0; i < 6; i++) if (obs[t0 + i] !== exp[i]) bad++;
    if (bad != 0) begin errors++; $display("FAIL tlr_tdi_tms: got %0d bad packets want 0", bad); end
  endtask

  task automatic test_random_packets();
    logic tdo_v, oe_v;
    logic [1:0] exp [10];
    int t0, bad, oe_bad;
    t0 = obs_n; bad = 0; oe_bad = 0;
    for (int i = 0; i < 10; i++) begin
      exp[i] = 2'($urandom);
      send_packet(exp[i][1], exp[i][0], tdo_v, oe_v);
      if (oe_v !== 1'b1) oe_bad++;
    end
    checks += 3;
    if (obs_n - t0 != 10) begin errors++; $display("FAIL rand_pulses: got %0d want 10", obs_n - t0); end
    for (int i = 0; i < 10; i++) if (obs[t0 + i] !== exp[i]) bad++;
    if (bad != 0) begin errors++; $display("FAIL rand_tdi_tms: got %0d bad packets want 0", bad); end
    if (oe_bad != 0) begin errors++; $display("FAIL rand_tdo_oe: got %0d bad want 0", oe_bad); end
  endtask

  task automatic test_idcode();
    logic tdo_v, oe_v;
    logic [31:0] rec;
    logic tms_seq [43];
    int oe_bad;
    for (int i = 0; i < 43; i++) tms_seq[i] = 1'b0;
    for (int i = 0; i < 5; i++) tms_seq[i] = 1'b1;   // Test-Logic-Reset (IR=IDCODE)
    tms_seq[6] = 1'b1;                               // Select-DR
    tms_seq[40] = 1'b1;                              // Exit1-DR
    tms_seq[41] = 1'b1;                              // Update-DR
    rec = '0; oe_bad = 0;
    for (int i = 0; i < 43; i++) begin
      send_packet(1'($urandom), tms_seq[i], tdo_v, oe_v);
      if (i >= 8 && i <= 39) begin
        rec[i - 8] = tdo_v;
        if (oe_v !== 1'b1) oe_bad++;
      end
    end
    checks += 3;
    if (rec !== idcode_val) begin
      errors++; $display("FAIL idcode_value: got %08h want %08h", rec, idcode_val);
    end
    if (oe_bad != 0) begin errors++; $display("FAIL idcode_oe: got %0d bad want 0", oe_bad); end
    if (tap_state != RTI) begin
      errors++; $display("FAIL idcode_tap_state: got %0d want %0d", tap_state, RTI);
    end
  endtask

  task automatic test_deselect();
    logic tdo_v, oe_v;
    int t0, o0;
    checks++;
    if (online !== 1'b1) begin errors++; $display("FAIL desel_pre: got %b want 1", online); end
    escape(4 + int'($urandom_range(0, 1)));
    checks++;
    if (online !== 1'b0) begin errors++; $display("FAIL desel_online: got %b want 0", online); end
    t0 = obs_n; o0 = oe_cnt;
    for (int i = 0; i < 3; i++) send_packet(1'($urandom), 1'($urandom), tdo_v, oe_v);
    checks += 2;
    if (obs_n != t0) begin errors++; $display("FAIL desel_tck: got %0d pulses want 0", obs_n - t0); end
    if (oe_cnt != o0) begin errors++; $display("FAIL desel_oe: got %0d cycles want 0", oe_cnt - o0); end
  endtask

  task automatic test_bad_oac();
    logic tdo_v, oe_v;
    int t0, n0;
    escape(6 + int'($urandom_range(0, 1)));
    n0 = online_cnt;
    send_oac(12'h00d);
    clk_wait(2);
    t0 = obs_n;
    for (int i = 0; i < 2; i++) send_packet(1'($urandom), 1'($urandom), tdo_v, oe_v);
    checks += 2;
    if (online_cnt != n0) begin
      errors++; $display("FAIL bad_oac_online: got %0d cycles want 0", online_cnt - n0);
    end
    if (obs_n != t0) begin errors++; $display("FAIL bad_oac_tck: got %0d pulses want 0", obs_n - t0); end
  endtask

  task automatic test_reset_escape();
    int l0, b0;
    activate();
    checks++;
    if (online !== 1'b1) begin errors++; $display("FAIL rst_esc_pre: got %b want 1", online); end
    l0 = trst_lo_cnt; b0 = trst_tms_bad;
    escape(8 + int'($urandom_range(0, 2)));
    checks++;
    if (online !== 1'b0) begin errors++; $display("FAIL rst_esc_online: got %b want 0", online); end
`ifdef HAZARD3_CJTAG_ESC_RESET_EN
    checks += 2;
    if (trst_lo_cnt - l0 != 2) begin
      errors++; $display("FAIL rst_esc_trst_len: got %0d clk want 2", trst_lo_cnt - l0);
    end
    if (trst_tms_bad != b0) begin
      errors++; $display("FAIL rst_esc_tms: got %0d cycles tms!=1 want 0", trst_tms_bad - b0);
    end
`endif
  endtask

  task automatic test_async_reset();
    int waited;
    activate();
    tckc_bit(1'($urandom));
    tmsc_i = 1'($urandom);
    clk_wait(4);
    tckc = 1'b1;
    waited = 0;
    while (tck !== 1'b1 && waited < 20) begin
      clk_wait(1);
      waited++;
    end
    checks++;
    if (tck !== 1'b1) begin errors++; $display("FAIL async_tck_rise: got %b want 1", tck); end
    #2 trst_n = 1'b0;
    #1;
    checks += 3;
    if (tck !== 1'b0) begin errors++; $display("FAIL async_tck: got %b want 0", tck); end
    if (online !== 1'b0) begin errors++; $display("FAIL async_online: got %b want 0", online); end
    if (tms !== 1'b1) begin errors++; $display("FAIL async_tms: got %b want 1", tms); end
    clk_wait(2);
    tckc = 1'b0;
    clk_wait(2);
    trst_n = 1'b1;
    clk_wait(4);
  endtask

  initial begin
    idcode_val = $urandom | 32'h1;
    test_reset();
    test_idle_offline();
    test_activate();
    test_tlr_idle();
    test_random_packets();
    test_idcode();
    test_deselect();
    test_bad_oac();
    test_reset_escape();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
